// File: rtl/imem_loadable.sv
`default_nettype none
// ============================================================================
// Module   : imem_loadable
// Brief    : Instruction memory with a registered fetch port and a byte-serial
//            program loader. Define IMEM_CHECKSUM_EN for trailing-XOR checking.
// Revision : 1.0  initial release
// ============================================================================
module imem_loadable #(
    parameter int            IW        = 9,
    parameter int            AW        = 8,
    parameter int            DEPTH     = 256,
    parameter logic [IW-1:0] HALT_WORD = {IW{1'b1}}
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [AW-1:0] PC,
    input  logic          fetch_req,
    output logic [IW-1:0] Instr,
    output logic          Instr_valid,
    input  logic          load_start,
    input  logic [7:0]    load_data,
    input  logic          load_valid,
    output logic          load_ready,
    output logic          load_busy,
    output logic          load_done,
    output logic          load_err
);

    localparam int c_BPW  = (IW + 7) / 8;
    localparam int c_W8   = c_BPW * 8;
    localparam int c_BIW  = (c_BPW > 1) ? $clog2(c_BPW) : 1;
    localparam int c_IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_BIW-1:0] c_BLAST = c_BIW'(c_BPW - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CKSUM = 3'd3,
        S_DONE  = 3'd4
    } state_t;

`ifdef IMEM_CHECKSUM_EN
    localparam state_t c_AFTER_DATA = S_CKSUM;
`else
    localparam state_t c_AFTER_DATA = S_DONE;
`endif

    logic [IW-1:0]    r_mem [DEPTH];
    state_t           r_state;
    state_t           w_next;
    logic [AW-1:0]    r_ptr;
    logic             r_ptr_wrap;
    logic [7:0]       r_nwords;
    logic [7:0]       r_wcnt;
    logic [c_BIW-1:0] r_bidx;
    logic [c_W8-1:0]  r_asm;
    logic [c_W8-1:0]  w_asm_next;
    logic [IW-1:0]    r_instr;
    logic             r_valid;
    logic [IW-1:0]    w_rd_word;
    logic             w_busy;
    logic             w_go;
    logic             w_fetch;
    logic             w_accept;
    logic             w_last_byte;
    logic             w_last_word;
    logic             w_wr_en;

    assign w_busy      = (r_state == S_COUNT) || (r_state == S_DATA) || (r_state == S_CKSUM);
    assign w_go        = load_start && (r_state == S_IDLE);
    assign w_fetch     = fetch_req && !w_busy && !load_start;
    assign w_accept    = load_valid && w_busy;
    assign w_last_byte = (r_bidx == c_BLAST);
    assign w_last_word = (r_wcnt == (r_nwords - 8'd1));
    // Once the pointer has wrapped or passed DEPTH, remaining words are discarded.
    assign w_wr_en     = (r_state == S_DATA) && w_accept && w_last_byte
                         && (32'(r_ptr) < DEPTH) && !r_ptr_wrap;
    assign w_rd_word   = (32'(PC) < DEPTH) ? r_mem[PC[c_IDXW-1:0]] : HALT_WORD;

    always_comb begin
        w_asm_next = r_asm;
        w_asm_next[r_bidx*8 +: 8] = load_data;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (load_start) w_next = S_COUNT;
            S_COUNT: if (w_accept) w_next = (load_data == 8'd0) ? c_AFTER_DATA : S_DATA;
            S_DATA:  if (w_accept && w_last_byte && w_last_word) w_next = c_AFTER_DATA;
            S_CKSUM: if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_ptr_wrap <= 1'b0;
            r_nwords   <= 8'd0;
            r_wcnt     <= 8'd0;
            r_bidx     <= '0;
            r_asm      <= '0;
            r_instr    <= HALT_WORD;
            r_valid    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_fetch;
            if (w_go || w_busy) begin
                r_instr <= HALT_WORD;
            end else if (w_fetch) begin
                r_instr <= w_rd_word;
            end
            if (w_go) begin
                r_ptr      <= '0;
                r_ptr_wrap <= 1'b0;
                r_wcnt     <= 8'd0;
                r_bidx     <= '0;
            end else if ((r_state == S_COUNT) && w_accept) begin
                r_nwords <= load_data;
            end else if ((r_state == S_DATA) && w_accept) begin
                r_asm <= w_asm_next;
                if (w_last_byte) begin
                    r_bidx <= '0;
                    r_ptr  <= r_ptr + AW'(1);
                    r_wcnt <= r_wcnt + 8'd1;
                    if (&r_ptr) begin
                        r_ptr_wrap <= 1'b1;
                    end
                end else begin
                    r_bidx <= r_bidx + c_BIW'(1);
                end
            end
        end
    end

    // Storage is deliberately left out of reset so programs survive it.
    always_ff @(posedge Clk) begin
        if (!Reset && w_wr_en) begin
            r_mem[r_ptr[c_IDXW-1:0]] <= w_asm_next[IW-1:0];
        end
    end

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] r_xor;
    logic       r_err;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_xor <= 8'd0;
            r_err <= 1'b0;
        end else if (w_go) begin
            r_xor <= 8'd0;
            r_err <= 1'b0;
        end else if ((r_state == S_DATA) && w_accept) begin
            r_xor <= r_xor ^ load_data;
        end else if ((r_state == S_CKSUM) && w_accept) begin
            r_err <= (load_data != r_xor);
        end
    end

    assign load_err = r_err;
`else
    assign load_err = 1'b0;
`endif

    assign Instr       = r_instr;
    assign Instr_valid = r_valid;
    assign load_ready  = w_busy;
    assign load_busy   = w_busy;
    assign load_done   = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_imem_loadable.sv
`default_nettype none
// Bench for imem_loadable: directed loads and fetches compared every cycle
// against a byte-counting behavioural model, plus literal expectations.
module tb_imem_loadable;

    localparam int         IW    = 9;
    localparam int         AW    = 8;
    localparam int         DEPTH = 200;
    localparam int         BPW   = 2;
    localparam logic [8:0] HALT  = 9'h1FF;
`ifdef IMEM_CHECKSUM_EN
    localparam int         CK    = 1;
`else
    localparam int         CK    = 0;
`endif

    logic          clk        = 1'b0;
    logic          Reset      = 1'b1;
    logic [AW-1:0] PC         = '0;
    logic          fetch_req  = 1'b0;
    logic          load_start = 1'b0;
    logic [7:0]    load_data  = 8'd0;
    logic          load_valid = 1'b0;
    logic [IW-1:0] Instr;
    logic          Instr_valid;
    logic          load_ready;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    int checks = 0;
    int errors = 0;

    imem_loadable #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .Clk(clk), .Reset(Reset), .PC(PC), .fetch_req(fetch_req),
        .Instr(Instr), .Instr_valid(Instr_valid),
        .load_start(load_start), .load_data(load_data), .load_valid(load_valid),
        .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [8:0]  m_mem   [256];
    bit          m_known [256];
    bit          m_on, m_busy, m_done, m_err, m_valid, m_ik, m_have_n;
    logic [8:0]  m_instr;
    logic [15:0] m_word;
    logic [7:0]  m_xor;
    int          m_left, m_bcnt, m_ptr;

    task automatic model_step();
        bit idle, fok;
        if (Reset) begin
            m_on = 1; m_busy = 0; m_done = 0; m_err = 0; m_valid = 0;
            m_instr = HALT; m_ik = 1;
            return;
        end
        idle = !m_busy && !m_done;
        fok  = fetch_req && !m_busy && !load_start;
        m_valid = fok;
        if (m_busy || (idle && load_start)) begin
            m_instr = HALT; m_ik = 1;
        end else if (fok) begin
            if (int'(PC) < DEPTH) begin
                m_instr = m_mem[PC]; m_ik = m_known[PC];
            end else begin
                m_instr = HALT; m_ik = 1;
            end
        end
        m_done = 0;
        if (idle && load_start) begin
            m_busy = 1; m_have_n = 0; m_err = 0; m_xor = 0;
            m_ptr = 0; m_bcnt = 0; m_word = 0;
        end else if (m_busy && load_valid) begin
            if (!m_have_n) begin
                m_have_n = 1;
                m_left = int'(load_data) * BPW + CK;
            end else if (CK == 1 && m_left == 1) begin
                m_err = (load_data != m_xor);
                m_left = 0;
            end else begin
                m_xor  = m_xor ^ load_data;
                m_word = m_word | (16'(load_data) << (8 * m_bcnt));
                m_bcnt++;
                if (m_bcnt == BPW) begin
                    if (m_ptr < DEPTH) begin
                        m_mem[m_ptr] = m_word[8:0];
                        m_known[m_ptr] = 1;
                    end
                    m_ptr++; m_bcnt = 0; m_word = 0;
                end
                m_left--;
            end
            if (m_left == 0) begin
                m_busy = 0; m_done = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_on) begin
                chk("m_valid", 32'(Instr_valid), 32'(m_valid));
                chk("m_busy",  32'(load_busy),   32'(m_busy));
                chk("m_ready", 32'(load_ready),  32'(m_busy));
                chk("m_done",  32'(load_done),   32'(m_done));
                chk("m_err",   32'(load_err),    32'(m_err));
                if (m_ik) chk("m_instr", 32'(Instr), 32'(m_instr));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    logic [8:0] ldq [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int n;
        repeat (gap) tick();
        load_valid = 1; load_data = b; n = 0;
        do begin
            rdy = load_ready;
            tick();
            n++;
        end while (!rdy && n < 20);
        load_valid = 0;
        if (!rdy) chk("ready_timeout", 32'(rdy), 32'd1);
    endtask

    task automatic load_q(input int gap_every, input bit bad_ck);
        logic [7:0]  x;
        logic [15:0] w;
        int k;
        x = 8'd0; k = 0;
        load_start = 1; tick(); load_start = 0;
        send_byte(8'(ldq.size()), 0);
        foreach (ldq[i]) begin
            w = 16'(ldq[i]);
            for (int j = 0; j < BPW; j++) begin
                k++;
                send_byte(w[8*j +: 8], (gap_every > 0 && (k % gap_every) == 0) ? 1 : 0);
                x = x ^ w[8*j +: 8];
            end
        end
        if (CK == 1) send_byte(bad_ck ? 8'h00 : x, 0);
        chk("load_done", 32'(load_done), 32'd1);
        tick();
        chk("done_pulse", 32'(load_done), 32'd0);
    endtask

    task automatic fetch(input logic [7:0] pc, input logic [8:0] exp, input string nm);
        PC = pc; fetch_req = 1; tick(); fetch_req = 0;
        chk(nm, 32'(Instr), 32'(exp));
        chk({nm, "_v"}, 32'(Instr_valid), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset = 1;
        repeat (3) tick();
        chk("rst_instr", 32'(Instr), 32'h1FF);
        chk("rst_valid", 32'(Instr_valid), 32'd0);
        chk("rst_ready", 32'(load_ready), 32'd0);
        chk("rst_busy",  32'(load_busy), 32'd0);
        chk("rst_done",  32'(load_done), 32'd0);
        chk("rst_err",   32'(load_err), 32'd0);
        Reset = 0;
        tick();

        // three-word load and read-back
        ldq = '{9'h100, 9'h0FF, 9'h1FF};
        load_q(0, 1'b0);
        fetch(8'd0, 9'h100, "t1_pc0");
        fetch(8'd1, 9'h0FF, "t1_pc1");
        fetch(8'd2, 9'h1FF, "t1_pc2");

        // out-of-range address returns the halt word
        fetch(8'd200, 9'h1FF, "t2_pc200");

        // fetch held through a load: load wins, fetch resumes after done
        PC = 8'd1; fetch_req = 1; load_start = 1;
        tick();
        load_start = 0;
        chk("t4_valid", 32'(Instr_valid), 32'd0);
        chk("t4_instr", 32'(Instr), 32'h1FF);
        chk("t4_busy",  32'(load_busy), 32'd1);
        send_byte(8'h01, 0);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 1);
        if (CK == 1) send_byte(8'hA5, 0);
        chk("t4_done", 32'(load_done), 32'd1);
        chk("t4_instr_done", 32'(Instr), 32'h1FF);
        tick();
        chk("t4_resume",   32'(Instr), 32'h0FF);
        chk("t4_resume_v", 32'(Instr_valid), 32'd1);
        fetch_req = 0;
        fetch(8'd0, 9'h0A5, "t4_mem0");

`ifdef IMEM_CHECKSUM_EN
        ldq = '{9'h0A5};
        load_q(0, 1'b1);
        chk("t3_err", 32'(load_err), 32'd1);
        fetch(8'd0, 9'h0A5, "t3_mem0");
        ldq = '{9'h0A5};
        load_q(0, 1'b0);
        chk("t3_err_clr", 32'(load_err), 32'd0);
`endif

        // reset part-way through a load
        ldq = '{9'h011, 9'h022, 9'h033, 9'h044};
        load_q(3, 1'b0);
        load_start = 1; tick(); load_start = 0;
        send_byte(8'h04, 0);
        send_byte(8'h55, 0);
        send_byte(8'h01, 0);
        send_byte(8'h66, 2);
        send_byte(8'h01, 0);
        Reset = 1; tick(); Reset = 0;
        chk("t5_ready", 32'(load_ready), 32'd0);
        chk("t5_done",  32'(load_done), 32'd0);
        chk("t5_busy",  32'(load_busy), 32'd0);
        tick();
        chk("t5_nodone", 32'(load_done), 32'd0);
        fetch(8'd0, 9'h155, "t5_mem0");
        fetch(8'd1, 9'h166, "t5_mem1");
        fetch(8'd2, 9'h033, "t5_mem2");
        fetch(8'd3, 9'h044, "t5_mem3");

        // empty load: done two cycles after load_start
        load_start = 1; tick(); load_start = 0;
        load_valid = 1; load_data = 8'h00;
        tick();
`ifdef IMEM_CHECKSUM_EN
        chk("t6_wait_ck", 32'(load_done), 32'd0);
        tick();
`endif
        load_valid = 0;
        chk("t6_done", 32'(load_done), 32'd1);
        tick();

        // load_start while busy is ignored
        load_start = 1; tick(); load_start = 0;
        send_byte(8'h02, 0);
        load_start = 1; tick(); load_start = 0;
        chk("t7_still_busy", 32'(load_busy), 32'd1);
        send_byte(8'h34, 0);
        send_byte(8'h01, 0);
        send_byte(8'h78, 0);
        send_byte(8'h00, 0);
        if (CK == 1) send_byte(8'h34 ^ 8'h01 ^ 8'h78, 0);
        chk("t7_done", 32'(load_done), 32'd1);
        tick();
        fetch(8'd0, 9'h134, "t7_mem0");
        fetch(8'd1, 9'h078, "t7_mem1");

        // 201 words with gaps: last word lands past DEPTH and is dropped
        ldq.delete();
        for (int i = 0; i < 201; i++) ldq.push_back(9'((i * 37 + 5) & 32'h1FF));
        load_q(7, 1'b0);
        fetch(8'd0,   9'h005, "t8_mem0");
        fetch(8'd1,   9'h02A, "t8_mem1");
        fetch(8'd199, 9'h0C8, "t8_mem199");
        fetch(8'd200, 9'h1FF, "t8_pc200");
        tick();
        chk("t8_idle_valid", 32'(Instr_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
